uart_mmio_master: RTL and testbench
===================================

Name: uart_mmio_master

Overview:
- CPU-side initiator for the UART controller's MMIO interface: decodes CPU word loads/stores in a 3-register window into tx_wen/uart_din and rx_ren pulses, samples uart_dout, and returns read data with a one-cycle ack.
- Sits between the core's load/store unit and the mmio_bus UART signals.
- Stalls the CPU while TX is full, up to a bounded timeout.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the UART register window.
- TX_TIMEOUT, 1024, cycles a TX store may wait on tx_full before being dropped (≥1).
- RX_LAT, 1, cycles from rx_ren to valid uart_dout (FIFO read latency, 1..3).

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous, active-low reset
- cpu_addr  in  32  byte address of the access
- cpu_wen  in  1  store request, single-cycle strobe, sampled only when stall=0
- cpu_ren  in  1  load request, single-cycle strobe, sampled only when stall=0
- cpu_wdata  in  32  store data; bits [7:0] used
- cpu_rdata  out  32  load data, valid only while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse for any in-window access
- stall  out  1  high while an access is in progress; CPU holds its request fields stable
- tx_wen  out  1  one-cycle TX FIFO write strobe
- uart_din  out  8  TX byte
- tx_full  in  1  TX FIFO full
- rx_ren  out  1  one-cycle RX FIFO read strobe
- uart_dout  in  8  RX FIFO data
- rx_data_present  in  1  RX FIFO non-empty

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 TXDATA, write-only.
  - 0x4 RXDATA, read-only.
  - 0x8 STATUS, read-only: bit0 rx_data_present, bit1 tx_full, bit2 tx_drop (sticky), others 0.
- Address decode and access rules:
  - Access is in-window iff cpu_addr[31:4]==BASE_ADDR[31:4] and cpu_addr[3:2]!=2'b11; outside the window, ignored with no ack and no stall.
  - Write to RXDATA/STATUS, or read of TXDATA: acked next cycle, no side effect, rdata=0.
  - If cpu_wen and cpu_ren are both high: write wins; read dropped.
- Reset (Rst low, async): state IDLE, all outputs 0, uart_din=0, tx_drop=0, timeout counter=0.
- FSM: IDLE, TX_WAIT, RX_WAIT, ACK.
- IDLE:
  - TXDATA store with tx_full=0: tx_wen=1 and uart_din=wdata[7:0] registered next cycle, then go to ACK. Store-to-ack latency is 2 cycles.
  - TXDATA store with tx_full=1: latch the byte, go to TX_WAIT, counter=0.
  - RXDATA load with rx_data_present=1: rx_ren=1 next cycle, go to RX_WAIT with latency counter=RX_LAT.
  - RXDATA load with rx_data_present=0: non-blocking; go to ACK with rdata=32'hFFFF_FFFF.
  - STATUS load: go to ACK with the snapshot taken at the request cycle, and clear tx_drop in the same cycle the snapshot is taken. If a drop occurs in that same cycle, set wins.
- TX_WAIT:
  - Each cycle with tx_full=0: issue tx_wen with the latched byte, go to ACK.
  - Otherwise increment the counter. When counter==TX_TIMEOUT-1 and still full: drop the byte, set tx_drop, go to ACK.
  - A TX store is never written twice.
- RX_WAIT: decrement the counter each cycle; at 0, capture uart_dout into rdata[7:0] (upper bits 0), go to ACK.
- ACK: cpu_ack=1 for exactly one cycle, then IDLE. New requests are sampled only in IDLE.
- stall = (state != IDLE) or (in-window request present in IDLE). It is combinational from the request and deasserts the same cycle cpu_ack is high.
- Strobe rules: tx_wen and rx_ren are never high in the same cycle, and each is exactly one cycle wide.
- Reset mid-operation: the transaction is abandoned, no ack, no strobes after reset assertion.

Test Plan:
- TX store: store 0x41 to BASE+0 with tx_full=0 -> tx_wen pulse with uart_din=0x41 exactly once; cpu_ack 2 cycles after the request.
- TX backpressure: tx_full=1 for 5 cycles then 0, store 0x5A -> stall held; tx_wen with 0x5A one cycle after tx_full falls; ack follows; tx_drop=0.
- TX timeout: TX_TIMEOUT=8, tx_full stuck 1 -> no tx_wen; ack after 8 wait cycles. STATUS read returns 0x6, then a second read returns 0x2.
- RX read: rx_data_present=1, FIFO model returns 0xC3 RX_LAT cycles after rx_ren -> single rx_ren pulse; cpu_rdata=0x0000_00C3 with cpu_ack. Repeat for RX_LAT=1 and 3.
- RX empty: rx_data_present=0, load BASE+4 -> no rx_ren; rdata=0xFFFF_FFFF; ack next cycle.
- Misc: simultaneous wen+ren, out-of-window access (no ack), and Rst asserted during TX_WAIT -> all outputs 0 immediately, no later tx_wen.

Source files
------------

// File: rtl/uart_mmio_master.sv
// uart_mmio_master
//
// CPU-side initiator for the UART controller's MMIO port. A word load/store that falls in the
// 3-register window at BASE_ADDR is turned into single-cycle tx_wen / rx_ren strobes towards the
// UART FIFOs. Each in-window access completes with a one-cycle cpu_ack pulse.
//
// Register window (offset from BASE_ADDR):
//   0x0 TXDATA  write-only, byte in wdata[7:0]
//   0x4 RXDATA  read-only, 0xFFFF_FFFF when the RX FIFO is empty
//   0x8 STATUS  read-only, {29'b0, tx_drop, tx_full, rx_data_present}; a read clears tx_drop
//
// Ports:
//   clk              system clock
//   Rst              asynchronous active-low reset
//   cpu_addr         byte address of the access
//   cpu_wen/cpu_ren  single-cycle store/load strobes, sampled only while stall is low
//   cpu_wdata        store data, bits [7:0] used
//   cpu_rdata        load data, valid while cpu_ack is high
//   cpu_ack          one-cycle completion pulse
//   stall            access in progress; the CPU holds its address/data stable
//   tx_wen/uart_din  TX FIFO write strobe and byte
//   tx_full          TX FIFO full
//   rx_ren           RX FIFO read strobe
//   uart_dout        RX FIFO data, valid RX_LAT cycles after rx_ren
//   rx_data_present  RX FIFO non-empty

module uart_mmio_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int unsigned TX_TIMEOUT = 1024,
  parameter int unsigned RX_LAT     = 1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        stall,
  output logic        tx_wen,
  output logic [7:0]  uart_din,
  input  logic        tx_full,
  output logic        rx_ren,
  input  logic [7:0]  uart_dout,
  input  logic        rx_data_present
);

  // One counter serves both the TX timeout and the RX read latency.
  localparam int unsigned CntW = (TX_TIMEOUT > 4) ? $clog2(TX_TIMEOUT) : 2;
  localparam logic [CntW-1:0] TxLast = CntW'(TX_TIMEOUT - 1);
  localparam logic [CntW-1:0] RxLoad = CntW'(RX_LAT);

  localparam logic [1:0] OffTx     = 2'b00;
  localparam logic [1:0] OffRx     = 2'b01;
  localparam logic [1:0] OffStatus = 2'b10;

  typedef enum logic [1:0] {StIdle, StTxWait, StRxWait, StAck} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_drop_q;
  logic            tx_wen_q;
  logic            rx_ren_q;
  logic            cpu_ack_q;
  logic [31:0]     cpu_rdata_q;
  logic [7:0]      uart_din_q;

  logic in_window;
  logic req_valid;

  // Upper store-data bits and the byte offset inside a word play no part in decode.
  logic unused_bits;
  assign unused_bits = ^{cpu_wdata[31:8], cpu_addr[1:0]};

  assign in_window = (cpu_addr[31:4] == BASE_ADDR[31:4]) && (cpu_addr[3:2] != 2'b11);
  assign req_valid = in_window && (cpu_wen || cpu_ren);

  // Requests are only accepted in StIdle, so outside it stall is simply "busy".
  assign stall = (state_q != StIdle) || req_valid;

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign tx_wen    = tx_wen_q;
  assign rx_ren    = rx_ren_q;
  assign uart_din  = uart_din_q;

  // cpu_ack is raised on the StAck -> StIdle step so that it lands in a cycle where stall has
  // already dropped. Accesses with no FIFO side effect skip StAck and ack on the next cycle.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_drop_q   <= 1'b0;
      tx_wen_q    <= 1'b0;
      rx_ren_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      uart_din_q  <= '0;
    end else begin
      tx_wen_q  <= 1'b0;
      rx_ren_q  <= 1'b0;
      cpu_ack_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (cpu_wen) begin
              // Write wins over a simultaneous read.
              if (cpu_addr[3:2] == OffTx) begin
                uart_din_q  <= cpu_wdata[7:0];
                cpu_rdata_q <= '0;
                if (tx_full) begin
                  cnt_q   <= '0;
                  state_q <= StTxWait;
                end else begin
                  tx_wen_q <= 1'b1;
                  state_q  <= StAck;
                end
              end else begin
                cpu_rdata_q <= '0;
                cpu_ack_q   <= 1'b1;
              end
            end else begin
              case (cpu_addr[3:2])
                OffRx: begin
                  if (rx_data_present) begin
                    rx_ren_q <= 1'b1;
                    cnt_q    <= RxLoad;
                    state_q  <= StRxWait;
                  end else begin
                    cpu_rdata_q <= '1;
                    cpu_ack_q   <= 1'b1;
                  end
                end
                OffStatus: begin
                  cpu_rdata_q <= {29'd0, tx_drop_q, tx_full, rx_data_present};
                  tx_drop_q   <= 1'b0;
                  cpu_ack_q   <= 1'b1;
                end
                default: begin
                  cpu_rdata_q <= '0;
                  cpu_ack_q   <= 1'b1;
                end
              endcase
            end
          end
        end

        StTxWait: begin
          // A free slot takes priority over the timeout on the final wait cycle.
          if (!tx_full) begin
            tx_wen_q <= 1'b1;
            state_q  <= StAck;
          end else if (cnt_q == TxLast) begin
            tx_drop_q <= 1'b1;
            state_q   <= StAck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StRxWait: begin
          if (cnt_q == '0) begin
            cpu_rdata_q <= {24'd0, uart_dout};
            state_q     <= StAck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StAck: begin
          cpu_ack_q <= 1'b1;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_master.sv
// Bench for uart_mmio_master. Two instances share the CPU/TX stimulus and differ only in
// RX_LAT (1 and 3); each has its own RX FIFO model that presents the byte only in the cycle
// RX_LAT after its rx_ren and the inverted byte at all other times.
module tb_uart_mmio_master;
  localparam logic [31:0] Base = 32'h0000_0400;
  localparam int TxTo = 8;
  localparam int Win  = 13;

  logic        clk        = 1'b0;
  logic        Rst        = 1'b0;
  logic [31:0] cpu_addr   = '0;
  logic [31:0] cpu_wdata  = '0;
  logic        cpu_wen    = 1'b0;
  logic        cpu_ren    = 1'b0;
  logic        tx_full    = 1'b0;
  logic        rx_present = 1'b0;
  logic [7:0]  rx_byte    = '0;

  logic [31:0] rdata  [2];
  logic        ack    [2];
  logic        stall  [2];
  logic        tx_wen [2];
  logic        rx_ren [2];
  logic [7:0]  din    [2];
  logic [7:0]  dout   [2];
  logic [2:0]  hist0 = '0;
  logic [2:0]  hist1 = '0;

  int   total    = 0;
  int   bad      = 0;
  logic exp_drop = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist0 <= {hist0[1:0], rx_ren[0]};
    hist1 <= {hist1[1:0], rx_ren[1]};
  end
  assign dout[0] = hist0[0] ? rx_byte : ~rx_byte;
  assign dout[1] = hist1[2] ? rx_byte : ~rx_byte;

  uart_mmio_master #(.BASE_ADDR(Base), .TX_TIMEOUT(TxTo), .RX_LAT(1)) u_dut_lat1 (
    .clk(clk), .Rst(Rst), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[0]), .cpu_ack(ack[0]), .stall(stall[0]),
    .tx_wen(tx_wen[0]), .uart_din(din[0]), .tx_full(tx_full), .rx_ren(rx_ren[0]),
    .uart_dout(dout[0]), .rx_data_present(rx_present)
  );

  uart_mmio_master #(.BASE_ADDR(Base), .TX_TIMEOUT(TxTo), .RX_LAT(3)) u_dut_lat3 (
    .clk(clk), .Rst(Rst), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[1]), .cpu_ack(ack[1]), .stall(stall[1]),
    .tx_wen(tx_wen[1]), .uart_din(din[1]), .tx_full(tx_full), .rx_ren(rx_ren[1]),
    .uart_dout(dout[1]), .rx_data_present(rx_present)
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s rdata u%0d", tag, i), rdata[i], 32'h0);
      chk($sformatf("%s outputs u%0d", tag, i),
          {20'd0, ack[i], stall[i], tx_wen[i], rx_ren[i], din[i]}, 32'h0);
    end
  endtask

  // One CPU access. tx_full is high during cycles 0..f-1 (cycle 0 = request cycle).
  task automatic xact(input string name, input logic [31:0] a, input logic w, input logic r,
                      input logic [31:0] wd, input int f, input logic pres,
                      input logic [7:0] rb);
    logic        inwin, full0, set_drop, clr_drop, chk_rd;
    logic [1:0]  ofs;
    logic [31:0] e_rd;
    int          e_ack [2];
    int          e_wen, e_wcyc, e_ren;
    int          ack_cyc [2], ack_n [2], wen_n [2], wen_cyc [2], ren_n [2], both [2];
    logic [31:0] rd_obs [2];
    logic [7:0]  wbyte [2];
    logic        st0 [2], st_ack [2], st_pre [2];

    // Reference expectations from the register-map and latency rules.
    inwin    = (a[31:4] == Base[31:4]) && (a[3:2] != 2'b11) && (w || r);
    ofs      = a[3:2];
    full0    = (f > 0);
    e_rd     = '0;
    e_wen    = 0;
    e_wcyc   = -1;
    e_ren    = 0;
    set_drop = 1'b0;
    clr_drop = 1'b0;
    chk_rd   = 1'b0;
    for (int i = 0; i < 2; i++) e_ack[i] = -1;
    if (inwin) begin
      if (w && ofs == 2'b00) begin
        if (f == 0) begin
          e_wen = 1; e_wcyc = 1;
          for (int i = 0; i < 2; i++) e_ack[i] = 2;
        end else if (f <= TxTo) begin
          e_wen = 1; e_wcyc = f + 1;
          for (int i = 0; i < 2; i++) e_ack[i] = f + 2;
        end else begin
          set_drop = 1'b1;
          for (int i = 0; i < 2; i++) e_ack[i] = TxTo + 2;
        end
      end else begin
        chk_rd = 1'b1;
        for (int i = 0; i < 2; i++) e_ack[i] = 1;
        if (!w && ofs == 2'b01 && pres) begin
          e_ren = 1;
          e_rd  = {24'd0, rb};
          for (int i = 0; i < 2; i++) e_ack[i] = lat_of(i) + 3;
        end else if (!w && ofs == 2'b01) begin
          e_rd = 32'hFFFF_FFFF;
        end else if (!w && ofs == 2'b10) begin
          e_rd     = {29'd0, exp_drop, full0, pres};
          clr_drop = 1'b1;
        end
      end
    end

    @(negedge clk);
    cpu_addr = a; cpu_wen = w; cpu_ren = r; cpu_wdata = wd;
    tx_full = full0; rx_present = pres; rx_byte = rb;
    #1;
    for (int i = 0; i < 2; i++) begin
      st0[i] = stall[i]; ack_cyc[i] = -1; ack_n[i] = 0; wen_n[i] = 0; wen_cyc[i] = -1;
      ren_n[i] = 0; both[i] = 0; rd_obs[i] = 'x; wbyte[i] = 'x; st_ack[i] = 1'bx;
      st_pre[i] = 1'bx;
    end
    for (int k = 1; k <= Win; k++) begin
      @(negedge clk);
      cpu_wen = 1'b0; cpu_ren = 1'b0; tx_full = (k < f);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          ack_n[i]++;
          if (ack_cyc[i] < 0) begin
            ack_cyc[i] = k; rd_obs[i] = rdata[i]; st_ack[i] = stall[i];
          end
        end
        if (tx_wen[i]) begin wen_n[i]++; wen_cyc[i] = k; wbyte[i] = din[i]; end
        if (rx_ren[i]) ren_n[i]++;
        if (tx_wen[i] && rx_ren[i]) both[i]++;
        if (k == e_ack[i] - 1) st_pre[i] = stall[i];
      end
    end
    tx_full = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s stall_req u%0d", name, i), st0[i], inwin);
      chk($sformatf("%s ack_cycle u%0d", name, i), ack_cyc[i], e_ack[i]);
      chk($sformatf("%s ack_count u%0d", name, i), ack_n[i], inwin ? 1 : 0);
      if (chk_rd) chk($sformatf("%s rdata u%0d", name, i), rd_obs[i], e_rd);
      chk($sformatf("%s tx_wen_count u%0d", name, i), wen_n[i], e_wen);
      if (e_wen == 1) begin
        chk($sformatf("%s tx_wen_cycle u%0d", name, i), wen_cyc[i], e_wcyc);
        chk($sformatf("%s uart_din u%0d", name, i), wbyte[i], wd[7:0]);
      end
      chk($sformatf("%s rx_ren_count u%0d", name, i), ren_n[i], e_ren);
      chk($sformatf("%s strobe_overlap u%0d", name, i), both[i], 0);
      if (inwin) chk($sformatf("%s stall_at_ack u%0d", name, i), st_ack[i], 1'b0);
      if (e_ack[i] >= 2) chk($sformatf("%s stall_held u%0d", name, i), st_pre[i], 1'b1);
    end

    if (set_drop) exp_drop = 1'b1;
    else if (clr_drop) exp_drop = 1'b0;
  endtask

  initial begin
    int          fopts [6];
    int          n_wen, n_ack;
    logic [31:0] a;
    logic        w, r;
    fopts = '{0, 0, 1, 3, 8, 9};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    Rst = 1'b1;

    // Directed scenarios
    xact("tx_store",     Base,        1, 0, 32'h41, 0,   0, 8'h00);
    xact("tx_backpress", Base,        1, 0, 32'h5A, 5,   0, 8'h00);
    xact("status_clean", Base + 8,    0, 1, 32'h0,  0,   0, 8'h00);
    xact("tx_full_edge", Base,        1, 0, 32'h3C, TxTo, 0, 8'h00);
    xact("tx_timeout",   Base,        1, 0, 32'hE7, 100, 0, 8'h00);
    xact("status_drop",  Base + 8,    0, 1, 32'h0,  1,   0, 8'h00);
    xact("status_clear", Base + 8,    0, 1, 32'h0,  1,   0, 8'h00);
    xact("rx_read",      Base + 4,    0, 1, 32'h0,  0,   1, 8'hC3);
    xact("rx_empty",     Base + 4,    0, 1, 32'h0,  0,   0, 8'h55);
    xact("status_rx",    Base + 8,    0, 1, 32'h0,  0,   1, 8'h00);
    xact("wen_ren_rx",   Base + 4,    1, 1, 32'h77, 0,   1, 8'h12);
    xact("wen_ren_tx",   Base,        1, 1, 32'h19, 0,   1, 8'h34);
    xact("read_txdata",  Base,        0, 1, 32'h0,  0,   0, 8'h00);
    xact("write_status", Base + 8,    1, 0, 32'hFF, 0,   0, 8'h00);
    xact("hole_0xc",     Base + 12,   1, 0, 32'h66, 0,   0, 8'h00);
    xact("outside_hi",   Base + 16,   0, 1, 32'h0,  0,   1, 8'h21);
    xact("outside_zero", 32'h0,       1, 0, 32'h42, 0,   0, 8'h00);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(5))
        0:       a = Base;
        1:       a = Base + 4;
        2:       a = Base + 8;
        3:       a = Base + 12;
        4:       a = Base + 32'($urandom_range(11));
        default: a = $urandom();
      endcase
      case ($urandom_range(3))
        0:       begin w = 1'b1; r = 1'b0; end
        2:       begin w = 1'b1; r = 1'b1; end
        default: begin w = 1'b0; r = 1'b1; end
      endcase
      xact($sformatf("rand%0d", n), a, w, r, $urandom(), fopts[$urandom_range(5)],
           1'($urandom_range(1)), 8'($urandom()));
    end

    // Reset while a store waits on a full TX FIFO
    @(negedge clk);
    cpu_addr = Base; cpu_wdata = 32'h99; cpu_wen = 1'b1; tx_full = 1'b1;
    @(negedge clk);
    cpu_wen = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid stall_before u0", stall[0], 1'b1);
    chk("rst_mid stall_before u1", stall[1], 1'b1);
    Rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    @(negedge clk);
    Rst = 1'b1; tx_full = 1'b0;
    exp_drop = 1'b0;
    n_wen = 0; n_ack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (tx_wen[i]) n_wen++;
        if (ack[i]) n_ack++;
      end
    end
    chk("rst_mid no_tx_wen_after", n_wen, 0);
    chk("rst_mid no_ack_after", n_ack, 0);
    xact("status_after_rst", Base + 8, 0, 1, 32'h0, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
